sha256_msg_feeder: RTL and testbench

Upstream bus master for the sha256 register-mapped wrapper. It accepts a message as a stream of 32-bit big-endian words and applies SHA-256 padding and the 64-bit length field. It writes each 512-bit block into BLOCK0..15, issues init/next through CTRL, polls STATUS, and reads back DIGEST0..7. It removes all padding and sequencing work from software and from the DMA.

---
 rtl/sha256_msg_feeder.sv | 167 ++++++++++++++++
 tb/tb_sha256_msg_feeder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_feeder.sv
// sha256_msg_feeder: pads a 32-bit word stream into SHA-256 blocks and drives the register-mapped core to a digest
module sha256_msg_feeder #(
  parameter int SETTLE_CYCLES = 3,
  parameter logic [7:0] CORE_BASE = 8'h00
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data,
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid
);
  typedef enum logic [2:0] {IDLE, FILL, PAD, CTRL, SETTLE, POLL, DIGEST, DONE} state_t;
  localparam logic [15:0] SETTLE_N = 16'(SETTLE_CYCLES);
  state_t state, state_n;
  logic [4:0] wi;
  logic [63:0] len, add;
  logic first, more, ended, need80, lenblk, accept, lenblk_eff;
  logic [15:0] cnt;
  logic [2:0] dcnt;
  logic [223:0] dsr;
  logic cs_n, we_n;
  logic [7:0] address_n;
  logic [31:0] write_data_n, last_word, pad_word;
  logic [4:0] sh;
  assign accept = in_valid & in_ready;
  assign sh = {in_bytes, 3'b000};
  assign last_word = (in_bytes == 2'd0) ? in_data : (in_data & ~(32'hffff_ffff >> sh)) | (32'h8000_0000 >> sh);
  assign add = (in_last && in_bytes != 2'd0) ? {59'd0, sh} : 64'd32;
  // lenblk: the length field belongs in the block being built; false once the 0x80 marker lands past word 13
  assign lenblk_eff = need80 ? (wi <= 5'd13) : lenblk;
  assign pad_word = need80 ? 32'h8000_0000 : !lenblk ? 32'd0 :
                    (wi == 5'd14) ? len[63:32] : (wi == 5'd15) ? len[31:0] : 32'd0;
  assign busy = state != IDLE && state != DONE;
  assign digest_valid = state == DONE;
  always_comb begin
    state_n = state;
    cs_n = 1'b0;
    we_n = 1'b0;
    address_n = address;
    write_data_n = write_data;
    case (state)
      IDLE, FILL: if (accept) begin
        cs_n = 1'b1;
        we_n = 1'b1;
        address_n = CORE_BASE + 8'h10 + {3'b000, wi};
        write_data_n = in_last ? last_word : in_data;
        state_n = (wi == 5'd15) ? CTRL : in_last ? PAD : FILL;
      end
      PAD: begin
        cs_n = 1'b1;
        we_n = 1'b1;
        address_n = CORE_BASE + 8'h10 + {3'b000, wi};
        write_data_n = pad_word;
        state_n = (wi == 5'd15) ? CTRL : PAD;
      end
      CTRL: begin
        cs_n = 1'b1;
        we_n = 1'b1;
        address_n = CORE_BASE + 8'h08;
        write_data_n = first ? 32'h5 : 32'h6;
        state_n = SETTLE;
      end
      SETTLE: if (cnt == SETTLE_N) begin
        state_n = POLL;
        cs_n = 1'b1;
        address_n = CORE_BASE + 8'h09;
      end
      POLL: begin
        cs_n = 1'b1;
        address_n = CORE_BASE + 8'h09;
        if (read_data[0] && (more || read_data[1])) begin
          state_n = !more ? DIGEST : ended ? PAD : FILL;
          cs_n = !more;
          address_n = CORE_BASE + 8'h20;
        end
      end
      DIGEST: begin
        state_n = (dcnt == 3'd7) ? DONE : DIGEST;
        cs_n = dcnt != 3'd7;
        address_n = CORE_BASE + 8'h21 + {5'd0, dcnt};
      end
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cs <= 1'b0;
      we <= 1'b0;
      address <= 8'd0;
      write_data <= 32'd0;
      in_ready <= 1'b0;
      digest <= 256'd0;
      wi <= 5'd0;
      len <= 64'd0;
      first <= 1'b1;
      more <= 1'b0;
      ended <= 1'b0;
      need80 <= 1'b0;
      lenblk <= 1'b0;
      cnt <= 16'd0;
      dcnt <= 3'd0;
      dsr <= 224'd0;
    end else begin
      state <= state_n;
      cs <= cs_n;
      we <= we_n;
      address <= address_n;
      write_data <= write_data_n;
      in_ready <= state_n == IDLE || state_n == FILL;
      case (state)
        IDLE, FILL: if (accept) begin
          wi <= wi + 5'd1;
          len <= len + add;
          if (wi == 5'd15) more <= 1'b1;
          if (in_last) begin
            ended <= 1'b1;
            need80 <= in_bytes == 2'd0;
            lenblk <= wi == 5'd15 || (in_bytes != 2'd0 && wi <= 5'd13);
          end
        end
        PAD: begin
          wi <= wi + 5'd1;
          if (need80) begin
            need80 <= 1'b0;
            lenblk <= wi <= 5'd13;
          end
          if (wi == 5'd15) more <= !lenblk_eff;
          if (wi == 5'd15 && !lenblk_eff) lenblk <= 1'b1;
        end
        CTRL: begin
          first <= 1'b0;
          cnt <= 16'd0;
        end
        SETTLE: cnt <= cnt + 16'd1;
        POLL: if (state_n != POLL) begin
          wi <= 5'd0;
          dcnt <= 3'd0;
        end
        DIGEST: begin
          dcnt <= dcnt + 3'd1;
          dsr <= {dsr[191:0], read_data};
          if (dcnt == 3'd7) digest <= {dsr, read_data};
        end
        DONE: begin
          wi <= 5'd0;
          len <= 64'd0;
          first <= 1'b1;
          more <= 1'b0;
          ended <= 1'b0;
          need80 <= 1'b0;
          lenblk <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_feeder.sv
// tb_sha256_msg_feeder: feeder against a behavioural SHA-256 register wrapper with a write/digest scoreboard
module tb_sha256_msg_feeder;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_last, cs, we, busy, digest_valid;
  logic [31:0] in_data, write_data, read_data;
  logic [1:0] in_bytes;
  logic [7:0] address;
  logic [255:0] digest;
  always #5 clk = ~clk;
  sha256_msg_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .busy(busy), .digest(digest),
    .digest_valid(digest_valid)
  );
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] M448_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  int errors = 0, checks = 0, stall = 5, wait_left = 0, ctrl_writes = 0, dig_count = 0;
  bit track = 1'b1;
  logic dvalid, dv_prev = 1'b0, ready;
  logic [255:0] hreg;
  logic [31:0] blk_r [16];
  logic [511:0] blk_flat;
  logic [7:0] msg [$];
  logic [39:0] exp_wr [$];
  logic [255:0] exp_dig [$];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7] +
             (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, bb, c, d, e, f, g, hh} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {a + hin[255:224], bb + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96], f + hin[95:64], g + hin[63:32], hh + hin[31:0]};
  endfunction

  // behavioural register wrapper: BLOCK0..15 at 0x10, CTRL 0x08, STATUS 0x09, DIGEST 0x20
  always_comb begin
    blk_flat = '0;
    for (int i = 0; i < 16; i++) blk_flat[511 - 32*i -: 32] = blk_r[i];
  end
  assign ready = wait_left == 0;
  always_comb begin
    read_data = 32'd0;
    if (cs && !we && address == 8'h09) read_data = {30'd0, ready & dvalid, ready};
    else if (cs && !we && address[7:3] == 5'b00100) read_data = hreg[255 - 32*int'(address[2:0]) -: 32];
  end
  always @(posedge clk) begin
    if (reset) begin
      wait_left <= 0;
      dvalid <= 1'b0;
    end else if (cs && we && address == 8'h08) begin
      hreg <= compress(write_data[0] ? IV : hreg, blk_flat);
      wait_left <= stall;
      dvalid <= 1'b1;
    end else begin
      if (cs && we && address[7:4] == 4'h1) blk_r[address[3:0]] <= write_data;
      if (wait_left > 0) wait_left <= wait_left - 1;
    end
  end

  // bus and digest scoreboard
  always @(negedge clk) begin : mon
    logic [39:0] e;
    logic [255:0] d;
    if (!reset) begin
      if (cs && we && address == 8'h08) ctrl_writes++;
      if (cs && we && address[7:4] == 4'h1) begin
        checks++;
        if (wait_left != 0) begin
          errors++;
          $display("FAIL block_write_while_busy: addr %h while core busy (%0d left), required none", address, wait_left);
        end
      end
      if (wait_left != 0) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_while_busy: got %b, required 0", in_ready);
        end
      end
      if (cs && we && track) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL bus_write: got %h/%h, required no write", address, write_data);
        end else begin
          e = exp_wr.pop_front();
          if ({address, write_data} !== e) begin
            errors++;
            $display("FAIL bus_write: got addr %h data %h, required addr %h data %h", address, write_data, e[39:32], e[31:0]);
          end
        end
      end
      if (digest_valid) begin
        dig_count++;
        checks++;
        if ({busy, dv_prev} !== 2'b00) begin
          errors++;
          $display("FAIL done_pulse: busy=%b prev_valid=%b, required 0 0", busy, dv_prev);
        end
        if (track) begin
          checks++;
          if (exp_dig.size() == 0) begin
            errors++;
            $display("FAIL digest: got %h, required no digest", digest);
          end else begin
            d = exp_dig.pop_front();
            if (digest !== d) begin
              errors++;
              $display("FAIL digest: got %h, required %h", digest, d);
            end
          end
        end
      end
    end
    dv_prev = digest_valid;
  end

  task automatic set_msg_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic rand_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  task automatic prepare();
    logic [7:0] p [$];
    logic [63:0] bl;
    logic [255:0] h;
    logic [511:0] b;
    logic [31:0] w;
    p = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    h = IV;
    for (int k = 0; k < p.size() / 64; k++) begin
      for (int i = 0; i < 16; i++) begin
        w = {p[64*k + 4*i], p[64*k + 4*i + 1], p[64*k + 4*i + 2], p[64*k + 4*i + 3]};
        b[511 - 32*i -: 32] = w;
        exp_wr.push_back({8'(16 + i), w});
      end
      exp_wr.push_back({8'h08, (k == 0) ? 32'h5 : 32'h6});
      h = compress(h, b);
    end
    exp_dig.push_back(h);
  endtask

  task automatic drive_words(input int gap_pct);
    int nw, t;
    logic [31:0] w;
    nw = (msg.size() + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      for (int b = 0; b < 4; b++) w[31 - 8*b -: 8] = (4*i + b < msg.size()) ? msg[4*i + b] : 8'($urandom);
      in_valid = 1'b0;
      while ($urandom_range(99) < gap_pct) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data = w;
      in_last = i == nw - 1;
      in_bytes = 2'(msg.size() % 4);
      t = 0;
      while (in_ready !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
      if (t >= 2000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_after_first_word: got %b, required 1", busy);
        end
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_msg(input int gap_pct);
    int base, t;
    base = dig_count;
    t = 0;
    prepare();
    drive_words(gap_pct);
    while (dig_count == base && t < 5000) begin @(posedge clk); #1; t++; end
    checks++;
    if (dig_count == base) begin
      errors++;
      $display("FAIL digest_timeout: got no digest_valid, required one (len %0d)", msg.size());
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d outstanding, required 0 (len %0d)", exp_wr.size(), msg.size());
    end
    exp_wr.delete();
    exp_dig.delete();
  endtask

  task automatic check_ctrl(input string name, input int c0, input int n);
    checks++;
    if (ctrl_writes - c0 != n) begin
      errors++;
      $display("FAIL %s_ctrl_count: got %0d, required %0d", name, ctrl_writes - c0, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cs, we, in_ready, busy, digest_valid, address, write_data} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b %b %b %b %b %h %h, required all 0", cs, we, in_ready, busy, digest_valid, address, write_data);
    end
    checks++;
    if (digest !== 256'd0) begin
      errors++;
      $display("FAIL reset_digest: got %h, required 0", digest);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, cs} !== 2'b10) begin
      errors++;
      $display("FAIL idle_ready: got in_ready=%b cs=%b, required 1 0", in_ready, cs);
    end
  endtask

  task automatic test_abc();
    int c0;
    c0 = ctrl_writes;
    set_msg_str("abc");
    send_msg(0);
    check_ctrl("abc", c0, 1);
    checks++;
    if (digest !== ABC_DIG) begin
      errors++;
      $display("FAIL abc_digest: got %h, required %h", digest, ABC_DIG);
    end
  endtask

  task automatic test_55();
    int c0;
    c0 = ctrl_writes;
    rand_msg(55);
    send_msg(0);
    check_ctrl("len55", c0, 1);
  endtask

  task automatic test_56();
    int c0;
    c0 = ctrl_writes;
    set_msg_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg(0);
    check_ctrl("len56", c0, 2);
    checks++;
    if (digest !== M448_DIG) begin
      errors++;
      $display("FAIL len56_digest: got %h, required %h", digest, M448_DIG);
    end
  endtask

  task automatic test_64();
    int c0;
    c0 = ctrl_writes;
    rand_msg(64);
    send_msg(0);
    check_ctrl("len64", c0, 2);
  endtask

  task automatic test_lengths();
    int lens [10] = '{1, 4, 52, 57, 59, 60, 61, 63, 119, 120};
    foreach (lens[i]) begin
      rand_msg(lens[i]);
      send_msg(20);
    end
  endtask

  task automatic test_slow_core();
    stall = 40;
    rand_msg(100);
    send_msg(40);
    stall = 5;
  endtask

  task automatic test_reset_in_poll();
    int t, c0;
    t = 0;
    track = 1'b0;
    stall = 60;
    set_msg_str("abc");
    c0 = ctrl_writes;
    drive_words(0);
    while (ctrl_writes == c0 && t < 500) begin @(posedge clk); #1; t++; end
    checks++;
    if (ctrl_writes == c0) begin
      errors++;
      $display("FAIL poll_reach: got no CTRL write, required one");
    end
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({cs, we, busy} !== 3'b000) begin
      errors++;
      $display("FAIL poll_reset: got cs=%b we=%b busy=%b, required 0 0 0", cs, we, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (cs !== 1'b0) begin
      errors++;
      $display("FAIL poll_reset_idle: got cs=%b, required 0", cs);
    end
    exp_wr.delete();
    exp_dig.delete();
    track = 1'b1;
    stall = 5;
    send_msg(0);
    checks++;
    if (digest !== ABC_DIG) begin
      errors++;
      $display("FAIL reset_abc_digest: got %h, required %h", digest, ABC_DIG);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data = 32'd0;
    in_last = 1'b0;
    in_bytes = 2'd0;
    test_reset();
    test_abc();
    test_55();
    test_56();
    test_64();
    test_lengths();
    test_slow_core();
    test_reset_in_poll();
    test_abc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
